// File: rtl/picorv32_mem_responder.sv
// Memory-side responder for the PicoRV32 native bus: wait states, byte-strobed
// word array, sticky range/protocol flags. Macro PICORV32_MEM_RESPONDER_LFSR_WAIT_EN
// selects pseudo-random wait states instead of the fixed WAIT_CYCLES.
module picorv32_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned MAX_WAIT    = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bad_addr,
  output logic        proto_err,
  output logic [15:0] req_count,
  output logic [15:0] fetch_count
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_MAX = (WAIT_CYCLES > MAX_WAIT) ? WAIT_CYCLES : MAX_WAIT;
  localparam int unsigned CW      = (CNT_MAX == 0) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_instr;
  logic [31:0]           r_rdata;
  logic                  r_bad_addr;
  logic                  r_proto_err;
  logic [15:0]           r_req_count;
  logic [15:0]           r_fetch_count;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic [31:0]           w_req_addr;
  logic [31:0]           w_req_wdata;
  logic [3:0]            w_req_wstrb;
  logic [31:0]           w_offset;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_index;
  logic [CW-1:0]         w_wait;
  logic                  w_enter_resp;
  logic                  w_mem_we;
  logic                  w_busy;
  logic                  w_violation;

`ifdef PICORV32_MEM_RESPONDER_LFSR_WAIT_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  always_comb begin
    if (32'(r_lfsr[3:0]) > MAX_WAIT) w_wait = CW'(MAX_WAIT);
    else                              w_wait = CW'(r_lfsr[3:0]);
  end
`else
  assign w_wait = CW'(WAIT_CYCLES);
`endif

  // A zero-wait request enters RESP on its accept edge, so decode must see the live bus then.
  assign w_accept    = (r_state == S_IDLE) && mem_valid;
  assign w_req_addr  = w_accept ? mem_addr  : r_addr;
  assign w_req_wdata = w_accept ? mem_wdata : r_wdata;
  assign w_req_wstrb = w_accept ? mem_wstrb : r_wstrb;

  assign w_offset   = w_req_addr - BASE_ADDR;
  assign w_in_range = (w_offset[1:0] == 2'b00) && (w_offset[31:DEPTH_LOG2+2] == '0);
  assign w_index    = w_offset[DEPTH_LOG2+1:2];

  assign w_enter_resp = (w_accept && (w_wait == '0)) ||
                        ((r_state == S_WAIT) && (r_cnt == CW'(1)));
  assign w_mem_we     = w_enter_resp && w_in_range && (w_req_wstrb != 4'b0000);

  assign w_busy      = (r_state == S_WAIT) || (r_state == S_RESP);
  assign w_violation = !mem_valid || (mem_addr != r_addr) ||
                       (mem_wdata != r_wdata) || (mem_wstrb != r_wstrb);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_instr       <= 1'b0;
      r_rdata       <= '0;
      r_bad_addr    <= 1'b0;
      r_proto_err   <= 1'b0;
      r_req_count   <= '0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_valid) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_instr <= mem_instr;
            r_cnt   <= w_wait;
            r_state <= (w_wait == '0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_RESP;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_count <= r_req_count + 16'd1;
          if (r_instr) r_fetch_count <= r_fetch_count + 16'd1;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_enter_resp) begin
        if (!w_in_range) begin
          r_rdata    <= '0;
          r_bad_addr <= 1'b1;
        end else if (w_req_wstrb == 4'b0000) begin
          r_rdata <= r_mem[w_index];
        end
      end

      if (w_busy && w_violation) r_proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_req_wstrb[b]) r_mem[w_index][8*b +: 8] <= w_req_wdata[8*b +: 8];
      end
    end
  end

  assign mem_ready   = (r_state == S_RESP);
  assign mem_rdata   = r_rdata;
  assign bad_addr    = r_bad_addr;
  assign proto_err   = r_proto_err;
  assign req_count   = r_req_count;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Bench for picorv32_mem_responder: two instances (0 and 3 fixed wait states)
// driven by per-scenario tasks with a queue of expected responses.
module tb_picorv32_mem_responder;

  localparam int LAT0 = 1;
  localparam int LAT1 = 4;
  localparam int MAXW = 7;

  typedef struct {
    int          d;
    logic [31:0] data;
    bit          chk;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid   [2];
  logic        instr   [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic        ready   [2];
  logic [31:0] rdata   [2];
  logic        bad     [2];
  logic        proto   [2];
  logic [15:0] reqc    [2];
  logic [15:0] fetchc  [2];

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  bit   seen_lat [64];

  always #5 clk = ~clk;

  picorv32_mem_responder #(
    .DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0), .MAX_WAIT(MAXW)
  ) u_dut0 (
    .clk(clk), .reset(reset), .mem_valid(valid[0]), .mem_instr(instr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
    .mem_ready(ready[0]), .mem_rdata(rdata[0]), .bad_addr(bad[0]),
    .proto_err(proto[0]), .req_count(reqc[0]), .fetch_count(fetchc[0])
  );

  picorv32_mem_responder #(
    .DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3), .MAX_WAIT(MAXW)
  ) u_dut1 (
    .clk(clk), .reset(reset), .mem_valid(valid[1]), .mem_instr(instr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
    .mem_ready(ready[1]), .mem_rdata(rdata[1]), .bad_addr(bad[1]),
    .proto_err(proto[1]), .req_count(reqc[1]), .fetch_count(fetchc[1])
  );

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the IDLE cycle after RESP
  // with the request still on the bus, so a follow-up call issues back-to-back.
  task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input bit ins, input logic [31:0] exp_d,
                        input bit chk);
    exp_t e;
    int   lat;
    bit   done;
    e.d = d; e.data = exp_d; e.chk = chk; e.lat = (d == 0) ? LAT0 : LAT1;
    sb.push_back(e);
    valid[d] = 1'b1; instr[d] = ins; addr[d] = a; wdata[d] = wd; wstrb[d] = st;
    @(negedge clk);
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ready[d] === 1'b1) done = 1'b1;
    end
    e = sb.pop_front();
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL req_timeout d=%0d addr=%h got no ready within %0d cycles", d, a, lat);
    end else begin
      seen_lat[lat] = 1'b1;
      if (e.chk) begin
        n_cmp++;
        if (rdata[d] !== e.data) begin
          n_fail++;
          $display("FAIL rdata d=%0d addr=%h got %h want %h", d, a, rdata[d], e.data);
        end
      end
`ifdef PICORV32_MEM_RESPONDER_LFSR_WAIT_EN
      if (lat < 1 || lat > MAXW + 1) begin
        n_fail++;
        $display("FAIL latency_range d=%0d got %0d want 1..%0d", d, lat, MAXW + 1);
      end
`else
      if (lat != e.lat) begin
        n_fail++;
        $display("FAIL latency d=%0d addr=%h got %0d want %0d", d, a, lat, e.lat);
      end
`endif
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ready[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_pulse d=%0d got %b want 0", d, ready[d]);
    end
  endtask

  task automatic idle(input int d);
    valid[d] = 1'b0; wstrb[d] = 4'h0; instr[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk16(input string name, input int d, input logic [15:0] got,
                       input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s d=%0d got %h want %h", name, d, got, want);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    valid[0] = 1'b1; addr[0] = 32'h10; wstrb[0] = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk16("rst_ready", d, 16'(ready[d]), 16'h0);
      chk16("rst_rdata_lo", d, rdata[d][15:0], 16'h0);
      chk16("rst_rdata_hi", d, rdata[d][31:16], 16'h0);
      chk16("rst_bad", d, 16'(bad[d]), 16'h0);
      chk16("rst_proto", d, 16'(proto[d]), 16'h0);
      chk16("rst_reqc", d, reqc[d], 16'h0);
      chk16("rst_fetchc", d, fetchc[d], 16'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0; valid[0] = 1'b0;
    @(negedge clk);
    chk16("rst_valid_ignored", 0, 16'(ready[0]), 16'h0);
    @(negedge clk);
    chk16("rst_no_req", 0, reqc[0], 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_wait0;
    do_req(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0);
    do_req(0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b1);
    idle(0);
    chk16("w0_reqc", 0, reqc[0], 16'd2);
    chk16("w0_fetchc", 0, fetchc[0], 16'd1);
    chk16("w0_proto", 0, 16'(proto[0]), 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_wait3_strobe;
    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0);
    do_req(1, 32'h10, 32'h000000AA, 4'h1, 1'b0, 32'h0, 1'b0);
    do_req(1, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEAA, 1'b1);
    do_req(1, 32'h12C, 32'h55667788, 4'hC, 1'b0, 32'h0, 1'b0);
    do_req(1, 32'h12C, 32'h0, 4'h0, 1'b0, 32'h5566_0000, 1'b0);
    idle(1);
    chk16("w3_reqc", 1, reqc[1], 16'd5);
    chk16("w3_proto", 1, 16'(proto[1]), 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_bad_addr;
    do_req(1, 32'h0, 32'h11111111, 4'hF, 1'b0, 32'h0, 1'b0);
    do_req(1, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEAA, 1'b1);
    chk16("bad_before", 1, 16'(bad[1]), 16'h0);
    do_req(1, 32'h1000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    chk16("bad_after_range", 1, 16'(bad[1]), 16'h1);
    do_req(1, 32'h1000, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0);
    do_req(1, 32'h2, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    chk16("bad_sticky", 1, 16'(bad[1]), 16'h1);
    do_req(1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h11111111, 1'b1);
    idle(1);
    chk16("bad_proto", 1, 16'(proto[1]), 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    do_req(1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, 1'b0);
    addr[1] = 32'h20; wdata[1] = 32'h0BADBEEF; wstrb[1] = 4'hF; instr[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; valid[1] = 1'b0;
    chk16("mid_ready", 1, 16'(ready[1]), 16'h0);
    chk16("mid_reqc", 1, reqc[1], 16'h0);
    chk16("mid_fetchc", 1, fetchc[1], 16'h0);
    chk16("mid_bad", 1, 16'(bad[1]), 16'h0);
    chk16("mid_reqc_other", 0, reqc[0], 16'h0);
    @(negedge clk);
    chk16("mid_idle", 1, 16'(ready[1]), 16'h0);
    @(posedge clk); #1;
    do_req(1, 32'h20, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b1);
    idle(1);
    chk16("mid_reqc_after", 1, reqc[1], 16'd1);
    @(posedge clk); #1;
  endtask

  task automatic test_proto;
    exp_t e;
    e.d = 1; e.data = 32'hCAFEF00D; e.chk = 1'b1; e.lat = LAT1;
    sb.push_back(e);
    valid[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h0; wstrb[1] = 4'h0; instr[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid[1] = 1'b0;
    @(negedge clk);
    chk16("proto_before", 1, 16'(proto[1]), 16'h0);
    @(negedge clk);
    chk16("proto_set", 1, 16'(proto[1]), 16'h1);
    chk16("proto_no_early_ready", 1, 16'(ready[1]), 16'h0);
    @(negedge clk);
    e = sb.pop_front();
    chk16("proto_ready_t4", 1, 16'(ready[1]), 16'h1);
    n_cmp++;
    if (rdata[1] !== e.data) begin
      n_fail++;
      $display("FAIL proto_rdata d=1 got %h want %h", rdata[1], e.data);
    end
    @(posedge clk); #1;
    chk16("proto_sticky", 1, 16'(proto[1]), 16'h1);
    chk16("proto_reqc", 1, reqc[1], 16'd2);
  endtask

  task automatic test_lfsr_random;
    logic [31:0] model [16];
    logic [31:0] wd;
    logic [3:0]  st;
    int          k;
    for (int i = 0; i < 64; i++) seen_lat[i] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      do_req(0, 32'h100 + 32'(4 * i), model[i], 4'hF, 1'b0, 32'h0, 1'b0);
    end
    for (int i = 0; i < 984; i++) begin
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        st = 4'($urandom_range(1, 15));
        wd = $urandom;
        for (int b = 0; b < 4; b++) if (st[b]) model[k][8*b +: 8] = wd[8*b +: 8];
        do_req(0, 32'h100 + 32'(4 * k), wd, st, 1'b0, 32'h0, 1'b0);
      end else begin
        do_req(0, 32'h100 + 32'(4 * k), 32'h0, 4'h0, 1'b1, model[k], 1'b1);
      end
    end
    idle(0);
    chk16("lfsr_proto", 0, 16'(proto[0]), 16'h0);
    for (int l = 1; l <= MAXW + 1; l++) chk16("lfsr_lat_seen", l, 16'(seen_lat[l]), 16'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog sim time exceeded got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; instr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
    end
    @(posedge clk); #1;
    test_reset();
    test_wait0();
    test_wait3_strobe();
    test_bad_addr();
`ifdef PICORV32_MEM_RESPONDER_LFSR_WAIT_EN
    test_lfsr_random();
`else
    test_reset_mid();
    test_proto();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
